// File: rtl/lut_bank_loader_if.sv
// ----------------------------------------------------------------------------
// lut_bank_loader_if
//
// Purpose:
//   Bundles the byte-stream input, vsync, the pixel-pipeline read port and the
//   loader status outputs of lut_bank_loader into one interface.
//
// Signals:
//   in_en      byte strobe from the SD reader
//   in_byte    file byte, valid when in_en=1
//   in_vsync   video vsync, synchronous to clk
//   rd_addr    LUT read address from the pixel pipeline
//   rd_data    registered LUT data from the active bank
//   lut_ready  an active bank holds a verified full table
//   lut_err    last load failed (short or overflow)
//   load_busy  a load is in progress or awaiting commit
//   byte_cnt   bytes received in the current/last load (saturating)
//
// Modports:
//   master  the side that feeds bytes/vsync and issues reads (SD reader,
//           pixel pipeline, testbench)
//   slave   the loader itself
// ----------------------------------------------------------------------------
interface lut_bank_loader_if #(
    parameter int AW = 10
);
    logic          in_en;
    logic [7:0]    in_byte;
    logic          in_vsync;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic          lut_ready;
    logic          lut_err;
    logic          load_busy;
    logic [AW:0]   byte_cnt;

    modport master (
        output in_en,
        output in_byte,
        output in_vsync,
        output rd_addr,
        input  rd_data,
        input  lut_ready,
        input  lut_err,
        input  load_busy,
        input  byte_cnt
    );

    modport slave (
        input  in_en,
        input  in_byte,
        input  in_vsync,
        input  rd_addr,
        output rd_data,
        output lut_ready,
        output lut_err,
        output load_busy,
        output byte_cnt
    );
endinterface

// File: rtl/lut_bank_loader.sv
// ----------------------------------------------------------------------------
// lut_bank_loader
//
// Purpose:
//   Captures a LUT file streamed byte-by-byte from the SD reader into the
//   inactive half of a double-buffered RAM, checks that exactly DEPTH bytes
//   arrived (the file is considered ended after TIMEOUT idle cycles), and
//   swaps banks only on a vsync rising edge so the pixel pipeline never sees
//   a half-written table. The active bank is read through a registered port.
//
// Parameters:
//   DEPTH    LUT entries per bank
//   TIMEOUT  idle cycles without a byte that end the file
//   AW       address width, 2**AW >= DEPTH
//
// Ports:
//   clk   system clock (same domain as the SD reader)
//   rst   synchronous, active-high reset
//   bus   lut_bank_loader_if.slave: in_en, in_byte, in_vsync, rd_addr in;
//         rd_data, lut_ready, lut_err, load_busy, byte_cnt out
// ----------------------------------------------------------------------------
module lut_bank_loader #(
    parameter int DEPTH   = 720,
    parameter int TIMEOUT = 4096,
    parameter int AW      = 10
) (
    input  logic              clk,
    input  logic              rst,
    lut_bank_loader_if.slave  bus
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   DEPTH_P1  = (AW+1)'(DEPTH + 1);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_ONE    = TW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_PEND  = 3'd2;
    localparam logic [2:0] S_READY = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]    state;
    logic          rd_bank;
    logic          vsync_d;
    logic          ovf;
    logic          lut_ready;
    logic          lut_err;
    logic          load_busy;
    logic [AW:0]   byte_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [7:0]    rd_data;

    // Both banks in one array: bank b occupies [b*DEPTH, b*DEPTH+DEPTH-1].
    logic [7:0]    ram [0:2*DEPTH-1];

    logic          idle_like;
    logic          vsync_rise;
    logic          wr_en;
    logic          rd_oob;
    logic [AW:0]   wr_idx;
    logic [AW:0]   rd_idx;

    // IDLE, READY and ERR all behave identically: any byte starts a new load.
    assign idle_like  = (state == S_IDLE) || (state == S_READY) || (state == S_ERR);
    assign vsync_rise = bus.in_vsync & ~vsync_d;
    assign rd_oob     = ({1'b0, bus.rd_addr} >= DEPTH_C);

    // Bytes beyond DEPTH are counted but never written, so a too-long file
    // cannot spill into the active bank.
    assign wr_en = bus.in_en & (idle_like | ((state == S_LOAD) && (byte_cnt < DEPTH_C)));

    always_comb begin
        // NOTE: every signal written here gets a value first, so no path
        // leaves it unassigned and no latch is inferred.
        wr_idx = '0;
        rd_idx = '0;
        // The first byte of a file always lands at entry 0; later bytes land
        // at the current count, which equals the next free entry.
        if (!idle_like) begin
            wr_idx = {1'b0, byte_cnt[AW-1:0]};
        end
        if (!rd_bank) begin
            wr_idx = wr_idx + DEPTH_C;
        end
        rd_idx = {1'b0, bus.rd_addr};
        if (rd_bank) begin
            rd_idx = rd_idx + DEPTH_C;
        end
    end

    // Loader state machine, bank select and status flags.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register in this block sees the pre-edge values of the others.
        if (rst) begin
            state       <= S_IDLE;
            rd_bank     <= 1'b0;
            vsync_d     <= 1'b0;
            ovf         <= 1'b0;
            lut_ready   <= 1'b0;
            lut_err     <= 1'b0;
            load_busy   <= 1'b0;
            byte_cnt    <= '0;
            timeout_cnt <= '0;
        end else begin
            vsync_d <= bus.in_vsync;

            case (state)
                S_IDLE, S_READY, S_ERR: begin
                    if (bus.in_en) begin
                        state       <= S_LOAD;
                        byte_cnt    <= CNT_ONE;
                        timeout_cnt <= '0;
                        ovf         <= 1'b0;
                        lut_err     <= 1'b0;
                        load_busy   <= 1'b1;
                    end
                end

                S_LOAD: begin
                    // A byte always wins over an expiring timeout.
                    if (bus.in_en) begin
                        timeout_cnt <= '0;
                        if (byte_cnt >= DEPTH_C) begin
                            ovf <= 1'b1;
                        end
                        if (byte_cnt != DEPTH_P1) begin
                            byte_cnt <= byte_cnt + CNT_ONE;
                        end
                    end else if (timeout_cnt == TO_LAST) begin
                        if (byte_cnt == DEPTH_C) begin
                            state <= S_PEND;
                        end else begin
                            state     <= S_ERR;
                            lut_err   <= 1'b1;
                            load_busy <= 1'b0;
                        end
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_ONE;
                    end
                end

                S_PEND: begin
                    // A byte arriving after the table is complete means the
                    // file was longer than it looked; refuse to commit it.
                    if (bus.in_en) begin
                        ovf <= 1'b1;
                    end
                    if (vsync_rise) begin
                        load_busy <= 1'b0;
                        if (ovf | bus.in_en) begin
                            state   <= S_ERR;
                            lut_err <= 1'b1;
                        end else begin
                            state     <= S_READY;
                            rd_bank   <= ~rd_bank;
                            lut_ready <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // NOTE: the table RAM is deliberately not reset; clearing 2*DEPTH
    // entries would prevent block-RAM mapping and nothing depends on it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_idx] <= bus.in_byte;
        end
    end

    // Registered read of the active bank. A swap on this edge only affects
    // reads sampled on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_oob) begin
            rd_data <= '0;
        end else begin
            rd_data <= ram[rd_idx];
        end
    end

    assign bus.rd_data   = rd_data;
    assign bus.lut_ready = lut_ready;
    assign bus.lut_err   = lut_err;
    assign bus.load_busy = load_busy;
    assign bus.byte_cnt  = byte_cnt;

endmodule

// File: tb/tb_lut_bank_loader.sv
// ----------------------------------------------------------------------------
// tb_lut_bank_loader
//
// Purpose:
//   Self-checking bench for lut_bank_loader (TIMEOUT shortened to 16). A
//   behavioural model tracks both banks as plain arrays plus a few
//   load-session facts (bytes seen, idle run, waiting for vsync, stray byte)
//   and every cycle its predictions are compared with the DUT outputs.
//   Directed scenarios add literal expectations; a randomized phase mixes
//   short, exact and long files with random gaps and vsync activity.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_lut_bank_loader;

    localparam int DEPTH   = 720;
    localparam int TIMEOUT = 16;
    localparam int AW      = 10;

    logic clk;
    logic rst;

    lut_bank_loader_if #(.AW(AW)) bus ();

    lut_bank_loader #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .AW      (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, $time, act, act, exp, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_mem [2][DEPTH];   // -1 = never written
    int m_active;           // bank the pixel pipeline reads
    bit m_loading;          // bytes are being collected
    bit m_waiting;          // full table collected, waiting for vsync
    bit m_extra;            // byte arrived while waiting
    bit m_ready;
    bit m_err;
    bit m_busy;
    bit m_vs_prev;
    int m_rx;               // bytes seen in this file (unsaturated)
    int m_idle;             // consecutive idle cycles while collecting
    int m_rd;               // expected rd_data, -1 = unknown
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        bit rise;
        int wb;
        if (rst) begin
            m_active  = 0;
            m_loading = 0;
            m_waiting = 0;
            m_extra   = 0;
            m_ready   = 0;
            m_err     = 0;
            m_busy    = 0;
            m_vs_prev = 0;
            m_rx      = 0;
            m_idle    = 0;
            m_rd      = 0;
        end else begin
            rise      = bus.in_vsync && !m_vs_prev;
            m_vs_prev = bus.in_vsync;
            m_rd      = (int'(bus.rd_addr) < DEPTH) ? m_mem[m_active][bus.rd_addr] : 0;
            wb        = 1 - m_active;
            if (m_waiting) begin
                if (bus.in_en) m_extra = 1;
                if (rise) begin
                    m_waiting = 0;
                    m_busy    = 0;
                    if (m_extra) begin
                        m_err = 1;
                    end else begin
                        m_active = wb;
                        m_ready  = 1;
                    end
                end
            end else if (m_loading) begin
                if (bus.in_en) begin
                    if (m_rx < DEPTH) m_mem[wb][m_rx] = int'(bus.in_byte);
                    m_rx++;
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_loading = 0;
                        if (m_rx == DEPTH) begin
                            m_waiting = 1;
                        end else begin
                            m_err  = 1;
                            m_busy = 0;
                        end
                    end
                end
            end else if (bus.in_en) begin
                m_mem[wb][0] = int'(bus.in_byte);
                m_rx      = 1;
                m_idle    = 0;
                m_loading = 1;
                m_extra   = 0;
                m_err     = 0;
                m_busy    = 1;
            end
        end
        m_valid = 1'b1;
    end

    // Cycle-by-cycle comparison, half a clock after the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("lut_ready", int'(bus.lut_ready), int'(m_ready));
            check("lut_err",   int'(bus.lut_err),   int'(m_err));
            check("load_busy", int'(bus.load_busy), int'(m_busy));
            check("byte_cnt",  int'(bus.byte_cnt),  (m_rx > DEPTH + 1) ? DEPTH + 1 : m_rx);
            if (m_rd >= 0) check("rd_data", int'(bus.rd_data), m_rd);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    bit hold_addr = 1'b0;
    bit rand_vs   = 1'b0;

    task automatic tick();
        if (!hold_addr) bus.rd_addr = AW'($urandom_range(0, (1 << AW) - 1));
        if (rand_vs && ($urandom_range(0, 15) == 0)) bus.in_vsync = ~bus.in_vsync;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.in_en = 1'b0;
        repeat (n) tick();
    endtask

    // mode 0: constant val, 1: low byte of index, 2: random
    task automatic send_bytes(input int n, input int mode, input logic [7:0] val);
        for (int i = 0; i < n; i++) begin
            bus.in_en   = 1'b1;
            bus.in_byte = (mode == 0) ? val : (mode == 1) ? 8'(i) : 8'($urandom);
            tick();
        end
        bus.in_en = 1'b0;
    endtask

    task automatic vsync_pulse();
        bus.in_vsync = 1'b1;
        tick();
        bus.in_vsync = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++)
                m_mem[b][a] = -1;

        rst          = 1'b1;
        bus.in_en    = 1'b0;
        bus.in_byte  = '0;
        bus.in_vsync = 1'b0;
        bus.rd_addr  = '0;
        @(negedge clk);
        repeat (3) tick();

        // Reset state
        check("rst lut_ready", int'(bus.lut_ready), 0);
        check("rst lut_err",   int'(bus.lut_err),   0);
        check("rst load_busy", int'(bus.load_busy), 0);
        check("rst byte_cnt",  int'(bus.byte_cnt),  0);
        check("rst rd_data",   int'(bus.rd_data),   0);
        rst = 1'b0;
        tick();

        // T2: short file
        send_bytes(DEPTH - 1, 2, 8'h00);
        idle(TIMEOUT);
        check("T2 lut_err",   int'(bus.lut_err),   1);
        check("T2 lut_ready", int'(bus.lut_ready), 0);
        check("T2 byte_cnt",  int'(bus.byte_cnt),  719);
        check("T2 load_busy", int'(bus.load_busy), 0);
        vsync_pulse();
        check("T2 no commit", int'(bus.lut_ready), 0);

        // T3: overflow
        send_bytes(DEPTH + 1, 1, 8'h00);
        idle(TIMEOUT);
        check("T3 lut_err",   int'(bus.lut_err),   1);
        check("T3 byte_cnt",  int'(bus.byte_cnt),  721);
        vsync_pulse();
        check("T3 no commit", int'(bus.lut_ready), 0);

        // T1: full load, commit on vsync, read back
        send_bytes(DEPTH, 1, 8'h00);
        idle(TIMEOUT);
        check("T1 pend busy",  int'(bus.load_busy), 1);
        check("T1 pend ready", int'(bus.lut_ready), 0);
        check("T1 pend cnt",   int'(bus.byte_cnt),  720);
        check("T1 pend err",   int'(bus.lut_err),   0);
        bus.in_vsync = 1'b1;
        tick();
        check("T1 ready", int'(bus.lut_ready), 1);
        check("T1 busy",  int'(bus.load_busy), 0);
        bus.in_vsync = 1'b0;
        hold_addr    = 1'b1;
        bus.rd_addr  = AW'(300);
        tick();
        check("T1 rd 300", int'(bus.rd_data), 8'h2C);
        bus.rd_addr = AW'(720);
        tick();
        check("T5 rd 720", int'(bus.rd_data), 0);
        bus.rd_addr = AW'(719);
        tick();
        check("T1 rd 719", int'(bus.rd_data), 719 % 256);
        hold_addr = 1'b0;

        // T4: reload while READY
        send_bytes(DEPTH, 0, 8'hAA);
        idle(TIMEOUT);
        vsync_pulse();
        hold_addr   = 1'b1;
        bus.rd_addr = AW'(5);
        send_bytes(DEPTH, 0, 8'h55);
        check("T4 old during load", int'(bus.rd_data),   8'hAA);
        check("T4 ready held",      int'(bus.lut_ready), 1);
        idle(TIMEOUT);
        check("T4 old in pend",     int'(bus.rd_data),   8'hAA);
        bus.in_vsync = 1'b1;
        tick();
        check("T4 old at commit",   int'(bus.rd_data),   8'hAA);
        bus.in_vsync = 1'b0;
        tick();
        check("T4 new after commit", int'(bus.rd_data),  8'h55);
        hold_addr = 1'b0;

        // T5: byte exactly at timeout expiry, vsync coincident with PEND entry
        send_bytes(700, 2, 8'h00);
        idle(TIMEOUT - 1);
        send_bytes(1, 2, 8'h00);
        check("T5 expiry busy", int'(bus.load_busy), 1);
        check("T5 expiry err",  int'(bus.lut_err),   0);
        check("T5 expiry cnt",  int'(bus.byte_cnt),  701);
        send_bytes(19, 2, 8'h00);
        idle(TIMEOUT - 1);
        bus.in_vsync = 1'b1;
        tick();
        check("T5 coincident no swap", int'(bus.load_busy), 1);
        tick();
        check("T5 held high no swap",  int'(bus.load_busy), 1);
        bus.in_vsync = 1'b0;
        tick();
        bus.in_vsync = 1'b1;
        tick();
        check("T5 next edge commits",  int'(bus.load_busy), 0);
        bus.in_vsync = 1'b0;
        tick();

        // T6: reset mid-load
        send_bytes(400, 2, 8'h00);
        rst = 1'b1;
        tick();
        check("T6 lut_ready", int'(bus.lut_ready), 0);
        check("T6 byte_cnt",  int'(bus.byte_cnt),  0);
        check("T6 load_busy", int'(bus.load_busy), 0);
        rst = 1'b0;
        tick();
        send_bytes(DEPTH, 2, 8'h00);
        idle(TIMEOUT);
        bus.in_vsync = 1'b1;
        tick();
        check("T6 reload ready", int'(bus.lut_ready), 1);
        bus.in_vsync = 1'b0;
        tick();

        // Randomized files: short, exact, long, exact plus a stray byte
        for (int k = 0; k < 10; k++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 3);
            case (kind)
                0:       n = $urandom_range(1, 60);
                1, 3:    n = DEPTH;
                default: n = DEPTH + $urandom_range(1, 4);
            endcase
            rand_vs = 1'b1;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 31) == 0) idle($urandom_range(1, TIMEOUT - 1));
                send_bytes(1, 2, 8'h00);
            end
            idle(TIMEOUT + $urandom_range(0, 3));
            rand_vs      = 1'b0;
            bus.in_vsync = 1'b0;
            tick();
            if (kind == 3) send_bytes(1, 2, 8'h00);
            vsync_pulse();
            vsync_pulse();
        end
        idle(TIMEOUT + 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
